// File: rtl/rgb_pixel_prefetch_avg.sv
// rgb_pixel_prefetch_avg: prefetches packed 24-bit RGB pixels from a 16-bit SRAM
// (2 pixels per 3 words), buffers them in a small FIFO and serves VGA pixel
// requests with a 10-bit, 2-tap horizontal average against the previous pixel.
module rgb_pixel_prefetch_avg #(
  parameter logic [17:0] BASE_ADDR  = 18'd0,
  parameter int          H_PIXELS   = 320,
  parameter int          V_LINES    = 240,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        frame_start,
  input  logic        row_start,
  input  logic        pixel_req,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [9:0]  VGA_red,
  output logic [9:0]  VGA_green,
  output logic [9:0]  VGA_blue,
  output logic        underflow
);

  localparam int TOTAL_WORDS = H_PIXELS * V_LINES * 3 / 2;
  localparam int WCW = $clog2(TOTAL_WORDS + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [WCW-1:0] TOTAL_W     = WCW'(TOTAL_WORDS);
  localparam logic [WCW-1:0] LAST_WORD   = WCW'(TOTAL_WORDS - 1);
  localparam logic [CW:0]    START_LEVEL = (CW + 1)'(FIFO_DEPTH - 2);
  localparam logic [PW-1:0]  LAST_SLOT   = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD0, S_RD1, S_RD2} state_t;

  state_t          state_q, state_d;
  logic [17:0]     addr_q, addr_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [1:0]      s1_phase_q, s1_phase_d, s2_phase_q, s2_phase_d;
  logic [15:0]     hold_q, hold_d;
  logic [29:0]     vga_q, vga_d;
  logic [29:0]     prev_q, prev_d;
  logic            first_q, first_d;
  logic            underflow_q, underflow_d;
  logic [23:0]     fifo_mem_q [FIFO_DEPTH];

  logic [CW:0]     level;
  logic            issue, start_ok, push, pop, first_eff;
  logic [23:0]     push_pixel, head;
  logic [29:0]     cur_pix, avg_pix;

  assign head = fifo_mem_q[rd_ptr_q];

  // Per channel: widen the byte to 10 bits and average with the previous pixel
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [9:0]  cur;
    logic [10:0] sum;
    assign cur = {head[gi*8 +: 8], 2'b00};
    assign sum = {1'b0, prev_q[gi*10 +: 10]} + {1'b0, cur};
    assign cur_pix[gi*10 +: 10] = cur;
    assign avg_pix[gi*10 +: 10] = 10'(sum >> 1);
  end

  // Fetch FSM: start a 3-word group only when the FIFO can absorb both pixels
  always_comb begin
    level      = {1'b0, count_q} + {1'b0, inflight_q};
    issue      = (state_q != S_IDLE);
    word_cnt_d = issue ? (word_cnt_q + WCW'(1)) : word_cnt_q;
    // the last word of the image leaves the address parked on it
    addr_d     = (issue && (word_cnt_q != LAST_WORD)) ? (addr_q + 18'd1) : addr_q;
    start_ok   = (level <= START_LEVEL) && (word_cnt_d < TOTAL_W);
    state_d    = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RD0;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = start_ok ? S_RD0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (frame_start) begin
      state_d    = S_IDLE;
      addr_d     = BASE_ADDR;
      word_cnt_d = '0;
    end
  end

  // Read-return tracking, byte unpacking and FIFO bookkeeping
  always_comb begin
    s1_valid_d = issue & ~frame_start;
    s1_phase_d = (state_q == S_RD0) ? 2'd0 : ((state_q == S_RD1) ? 2'd1 : 2'd2);
    s2_valid_d = s1_valid_q & ~frame_start;
    s2_phase_d = s1_phase_q;
    hold_d     = s2_valid_q ? SRAM_read_data : hold_q;
    push       = s2_valid_q && (s2_phase_q != 2'd0) && !frame_start;
    // word 1 completes pixel 0 with the held word 0; word 2 completes pixel 1
    push_pixel = (s2_phase_q == 2'd1) ? {hold_q, SRAM_read_data[15:8]}
                                      : {hold_q[7:0], SRAM_read_data};
    pop        = pixel_req && (count_q != '0) && !frame_start;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : (wr_ptr_q + PW'(1));
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : (rd_ptr_q + PW'(1));

    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);

    inflight_d = inflight_q;
    if (push) inflight_d = inflight_d - CW'(1);
    if (state_d == S_RD0) inflight_d = inflight_d + CW'(2);

    if (frame_start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
    end
  end

  // Output path: raw first pixel of a row, averaged afterwards, sticky underflow
  always_comb begin
    first_eff   = first_q | row_start;
    vga_d       = vga_q;
    prev_d      = prev_q;
    first_d     = first_eff;
    underflow_d = underflow_q;
    if (frame_start) begin
      vga_d   = '0;
      first_d = 1'b1;
    end else if (pop) begin
      vga_d   = first_eff ? cur_pix : avg_pix;
      prev_d  = cur_pix;
      first_d = 1'b0;
    end else if (pixel_req) begin
      underflow_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_ADDR;
      word_cnt_q  <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_phase_q  <= 2'd0;
      s2_valid_q  <= 1'b0;
      s2_phase_q  <= 2'd0;
      hold_q      <= '0;
      vga_q       <= '0;
      prev_q      <= '0;
      first_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_phase_q  <= s1_phase_d;
      s2_valid_q  <= s2_valid_d;
      s2_phase_q  <= s2_phase_d;
      hold_q      <= hold_d;
      vga_q       <= vga_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      underflow_q <= underflow_d;
    end
  end

  // Pixel storage; no reset needed because count_q gates every read
  always_ff @(posedge Clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_pixel;
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign VGA_red      = vga_q[29:20];
  assign VGA_green    = vga_q[19:10];
  assign VGA_blue     = vga_q[9:0];
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rgb_pixel_prefetch_avg.sv
// tb_rgb_pixel_prefetch_avg: directed bench with an SRAM model (2-cycle read
// latency) and a small averaging model on a reduced 8x4 image.
`timescale 1ns/1ps
module tb_rgb_pixel_prefetch_avg;

  localparam logic [17:0] BASE   = 18'd100;
  localparam int          HP     = 8;
  localparam int          VL     = 4;
  localparam int          NPIX   = HP * VL;
  localparam int          NWORDS = NPIX * 3 / 2;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        frame_start = 1'b0;
  logic        row_start = 1'b0;
  logic        pixel_req = 1'b0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [9:0]  VGA_red, VGA_green, VGA_blue;
  logic        underflow;
  logic [29:0] vga_pix;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  pr [NPIX];
  logic [7:0]  pg [NPIX];
  logic [7:0]  pb [NPIX];
  logic [17:0] a1_q, a2_q;
  int          sram_idx, sram_grp, sram_ph;

  int          m_idx;
  logic        m_first;
  logic [9:0]  m_pr, m_pg, m_pb;

  always #5 Clock = ~Clock;

  rgb_pixel_prefetch_avg #(
    .BASE_ADDR(BASE), .H_PIXELS(HP), .V_LINES(VL), .FIFO_DEPTH(4)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .frame_start(frame_start),
    .row_start(row_start), .pixel_req(pixel_req),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .VGA_red(VGA_red), .VGA_green(VGA_green), .VGA_blue(VGA_blue),
    .underflow(underflow)
  );

  assign vga_pix = {VGA_red, VGA_green, VGA_blue};

  // SRAM model: address pipelined twice so data is valid 2 cycles later
  always @(posedge Clock) begin
    a1_q <= SRAM_address;
    a2_q <= a1_q;
  end

  always_comb begin
    SRAM_read_data = 16'hDEAD;
    sram_idx = int'(a2_q) - int'(BASE);
    sram_grp = sram_idx / 3;
    sram_ph  = sram_idx % 3;
    if (sram_idx >= 0 && sram_idx < NWORDS) begin
      case (sram_ph)
        0:       SRAM_read_data = {pr[2*sram_grp], pg[2*sram_grp]};
        1:       SRAM_read_data = {pb[2*sram_grp], pr[2*sram_grp+1]};
        default: SRAM_read_data = {pg[2*sram_grp+1], pb[2*sram_grp+1]};
      endcase
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    m_first = 1'b1;
    m_idx   = 0;
  endtask

  task automatic do_pop(input logic with_row);
    if (with_row) m_first = 1'b1;
    row_start = with_row;
    pixel_req = 1'b1;
    cyc();
    pixel_req = 1'b0;
    row_start = 1'b0;
  endtask

  task automatic model_pop(output logic [29:0] exp_pix);
    logic [9:0] cr, cg, cb;
    cr = {pr[m_idx], 2'b00};
    cg = {pg[m_idx], 2'b00};
    cb = {pb[m_idx], 2'b00};
    if (m_first) exp_pix = {cr, cg, cb};
    else exp_pix = {10'((int'(m_pr) + int'(cr)) / 2),
                    10'((int'(m_pg) + int'(cg)) / 2),
                    10'((int'(m_pb) + int'(cb)) / 2)};
    m_pr = cr; m_pg = cg; m_pb = cb;
    m_first = 1'b0;
    m_idx++;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (SRAM_address !== BASE) begin
      n_bad++; $display("FAIL reset_addr: got %0d expected %0d", SRAM_address, BASE);
    end
    n_cmp++;
    if (SRAM_we_n !== 1'b1) begin
      n_bad++; $display("FAIL reset_we_n: got %b expected 1", SRAM_we_n);
    end
    n_cmp++;
    if (vga_pix !== 30'd0) begin
      n_bad++; $display("FAIL reset_vga: got %h expected 0", vga_pix);
    end
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_underflow: got %b expected 0", underflow);
    end
    Resetn = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    pulse_frame();
    repeat (12) cyc();
    row_start = 1'b1;
    cyc();
    row_start = 1'b0;
    do_pop(1'b0);
    n_cmp++;
    if (vga_pix !== {10'h3FC, 10'h040, 10'h080}) begin
      n_bad++; $display("FAIL basic_px0: got %h/%h/%h expected 3fc/040/080", VGA_red, VGA_green, VGA_blue);
    end
    cyc();
    do_pop(1'b0);
    n_cmp++;
    if (vga_pix !== {10'h2FE, 10'h0A0, 10'h040}) begin
      n_bad++; $display("FAIL basic_px1: got %h/%h/%h expected 2fe/0a0/040", VGA_red, VGA_green, VGA_blue);
    end
  endtask

  task automatic test_addr_seq();
    pulse_frame();
    n_cmp++;
    if (SRAM_address !== BASE) begin
      n_bad++; $display("FAIL addr_restart: got %0d expected %0d", SRAM_address, BASE);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++;
      if (SRAM_address !== BASE + 18'(i)) begin
        n_bad++; $display("FAIL addr_seq_%0d: got %0d expected %0d", i, SRAM_address, BASE + 18'(i));
      end
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (SRAM_address !== BASE + 18'd6 || SRAM_we_n !== 1'b1) begin
        n_bad++; $display("FAIL addr_stall_%0d: got addr %0d we_n %b expected addr %0d we_n 1",
                          i, SRAM_address, SRAM_we_n, BASE + 18'd6);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [29:0] exp_pix;
    pulse_frame();
    repeat (10) cyc();
    for (int row = 0; row < VL; row++) begin
      for (int px = 0; px < HP; px++) begin
        if (px == 0 && (row % 2) == 0) begin
          // separate row_start pulse ahead of the first request
          row_start = 1'b1;
          cyc();
          row_start = 1'b0;
          m_first = 1'b1;
        end
        // odd rows: row_start coincides with the first request
        do_pop(px == 0 && (row % 2) == 1);
        model_pop(exp_pix);
        n_cmp++;
        if (vga_pix !== exp_pix) begin
          n_bad++; $display("FAIL frame_r%0d_p%0d: got %h expected %h", row, px, vga_pix, exp_pix);
        end
        cyc();
      end
    end
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++; $display("FAIL frame_underflow: got %b expected 0", underflow);
    end
    repeat (10) cyc();
    n_cmp++;
    if (SRAM_address !== BASE + 18'(NWORDS - 1)) begin
      n_bad++; $display("FAIL frame_end_addr: got %0d expected %0d", SRAM_address, BASE + 18'(NWORDS - 1));
    end
    repeat (8) cyc();
    n_cmp++;
    if (SRAM_address !== BASE + 18'(NWORDS - 1)) begin
      n_bad++; $display("FAIL frame_end_hold: got %0d expected %0d", SRAM_address, BASE + 18'(NWORDS - 1));
    end
  endtask

  task automatic test_frame_abort();
    logic [29:0] exp_pix;
    int w;
    pulse_frame();
    repeat (12) cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL abort_pre0: got %h expected %h", vga_pix, exp_pix);
    end
    cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL abort_pre1: got %h expected %h", vga_pix, exp_pix);
    end
    // the refill group shows its third address once RD0 and RD1 are done
    w = 0;
    while (SRAM_address !== BASE + 18'd8 && w < 20) begin
      cyc();
      w++;
    end
    n_cmp++;
    if (w >= 20) begin
      n_bad++; $display("FAIL abort_wait_rd2: got addr %0d expected %0d within 20 cycles", SRAM_address, BASE + 18'd8);
    end
    pulse_frame();
    n_cmp++;
    if (SRAM_address !== BASE) begin
      n_bad++; $display("FAIL abort_addr: got %0d expected %0d", SRAM_address, BASE);
    end
    repeat (12) cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL abort_px0: got %h expected %h", vga_pix, exp_pix);
    end
    cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL abort_px1: got %h expected %h", vga_pix, exp_pix);
    end
  endtask

  task automatic test_underflow();
    logic [29:0] exp_pix;
    // request in the frame_start cycle itself must be ignored
    frame_start = 1'b1;
    pixel_req = 1'b1;
    cyc();
    frame_start = 1'b0;
    pixel_req = 1'b0;
    m_first = 1'b1;
    m_idx = 0;
    n_cmp++;
    if (underflow !== 1'b0 || vga_pix !== 30'd0) begin
      n_bad++; $display("FAIL uf_with_frame: got uf %b vga %h expected uf 0 vga 0", underflow, vga_pix);
    end
    do_pop(1'b0);
    n_cmp++;
    if (underflow !== 1'b1) begin
      n_bad++; $display("FAIL uf_flag: got %b expected 1", underflow);
    end
    n_cmp++;
    if (vga_pix !== 30'd0) begin
      n_bad++; $display("FAIL uf_vga_hold: got %h expected 0", vga_pix);
    end
    repeat (12) cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL uf_px0: got %h expected %h", vga_pix, exp_pix);
    end
    cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix || underflow !== 1'b1) begin
      n_bad++; $display("FAIL uf_px1: got %h uf %b expected %h uf 1", vga_pix, underflow, exp_pix);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] exp_pix;
    int w;
    pulse_frame();
    repeat (12) cyc();
    do_pop(1'b0);
    cyc();
    do_pop(1'b0);
    w = 0;
    while (SRAM_address !== BASE + 18'd8 && w < 20) begin
      cyc();
      w++;
    end
    n_cmp++;
    if (w >= 20) begin
      n_bad++; $display("FAIL rst_wait_rd2: got addr %0d expected %0d within 20 cycles", SRAM_address, BASE + 18'd8);
    end
    #2;
    Resetn = 1'b0;
    #1;
    n_cmp++;
    if (SRAM_address !== BASE || SRAM_we_n !== 1'b1) begin
      n_bad++; $display("FAIL rst_async_addr: got %0d we_n %b expected %0d we_n 1", SRAM_address, SRAM_we_n, BASE);
    end
    n_cmp++;
    if (vga_pix !== 30'd0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL rst_async_out: got vga %h uf %b expected 0 0", vga_pix, underflow);
    end
    repeat (2) cyc();
    Resetn = 1'b1;
    cyc();
    pulse_frame();
    repeat (12) cyc();
    do_pop(1'b1);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL rst_resume_px0: got %h expected %h", vga_pix, exp_pix);
    end
    cyc();
    do_pop(1'b0);
    model_pop(exp_pix);
    n_cmp++;
    if (vga_pix !== exp_pix) begin
      n_bad++; $display("FAIL rst_resume_px1: got %h expected %h", vga_pix, exp_pix);
    end
  endtask

  initial begin
    for (int p = 0; p < NPIX; p++) begin
      pr[p] = 8'(p * 37 + 11);
      pg[p] = 8'(p * 91 + 5);
      pb[p] = 8'(200 - p * 13);
    end
    pr[0] = 8'hFF; pg[0] = 8'h10; pb[0] = 8'h20;
    pr[1] = 8'h80; pg[1] = 8'h40; pb[1] = 8'h00;
    m_idx = 0; m_first = 1'b1; m_pr = '0; m_pg = '0; m_pb = '0;

    cyc();
    test_reset();
    test_basic();
    test_addr_seq();
    test_full_frame();
    test_frame_abort();
    test_underflow();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
